mul_ctrl: RTL and testbench

//  Sequencing/arbitration front end for the shared 33-bit radix-2 booth multiplier.

---
 rtl/rv32i_types.sv | 40 ++++
 rtl/mul_ctrl_booth.sv | 80 ++++++++
 rtl/mul_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mul_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32 types for the multiply cluster: words, mul op encoding, controller states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  // Encoding matches funct3[1:0] of the RV32M multiply group.
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mul_ctrl_state_t;

  typedef enum logic [1:0] {
    B_RDY  = 2'd0,
    B_CALC = 2'd1,
    B_DONE = 2'd2
  } booth_state_t;

  localparam int BOOTH_W    = 33;
  localparam int BOOTH_ITER = 33;

  // {licand_sign, lier_sign}; low-half MUL is sign-agnostic but runs signed.
  function automatic logic [1:0] mul_signs(input mul_op_t op);
    case (op)
      MUL, MULH: mul_signs = 2'b11;
      MULHSU:    mul_signs = 2'b10;
      default:   mul_signs = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mul_ctrl_booth.sv
// 33-bit radix-2 booth multiplier, one recode/add/shift step per cycle.
// Latency: load edge, 33 iterate cycles, then mult_resp held in DONE until mult drops.
// Backpressure: no abort; mult low freezes the iteration, mult low in DONE returns to ready.
module booth
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      mult,
  input  rv32i_word licand,
  input  rv32i_word lier,
  input  logic      licand_sign,
  input  logic      lier_sign,
  output logic      mult_resp,
  output rv32i_word product_l,
  output rv32i_word product_u
);

  booth_state_t       st;
  logic [BOOTH_W:0]   acc;    // one guard bit so A +/- M never overflows
  logic [BOOTH_W-1:0] m;
  logic [BOOTH_W-1:0] q;
  logic               q_m1;
  logic [5:0]         cnt;
  logic [BOOTH_W:0]   m_ext;
  logic [BOOTH_W:0]   sum;

  always_comb begin
    m_ext = {m[BOOTH_W-1], m};
    sum   = acc;
    case ({q[0], q_m1})
      2'b10:   sum = acc - m_ext;
      2'b01:   sum = acc + m_ext;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= B_RDY;
      acc  <= '0;
      m    <= '0;
      q    <= '0;
      q_m1 <= 1'b0;
      cnt  <= '0;
    end else begin
      case (st)
        B_RDY: begin
          if (mult) begin
            m    <= {licand_sign & licand[31], licand};
            q    <= {lier_sign & lier[31], lier};
            acc  <= '0;
            q_m1 <= 1'b0;
            cnt  <= '0;
            st   <= B_CALC;
          end
        end
        B_CALC: begin
          if (mult) begin
            // arithmetic shift right of {acc, q, q_m1}
            acc  <= {sum[BOOTH_W], sum[BOOTH_W:1]};
            q    <= {sum[0], q[BOOTH_W-1:1]};
            q_m1 <= q[0];
            cnt  <= cnt + 6'd1;
            if (cnt == 6'(BOOTH_ITER - 1)) st <= B_DONE;
          end
        end
        B_DONE: begin
          if (!mult) st <= B_RDY;
        end
        default: st <= B_RDY;
      endcase
    end
  end

  assign mult_resp = (st == B_DONE);
  assign product_l = q[31:0];
  assign product_u = {acc[30:0], q[32]};

endmodule

// File: rtl/mul_ctrl.sv
// Round-robin issue front end for the shared booth multiplier; optional MUL_FUSE_EN reuses the last product.
// Latency: accept to resp_valid 36 cycles (1 cycle on a fuse hit); one op in flight.
// Backpressure: req_ready only in IDLE without flush; resp held until resp_ready, flush drops it.
module mul_ctrl
  import rv32i_types::*;
#(
  parameter  int N_REQ = 2,
  parameter  int TAG_W = 6,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [32*N_REQ-1:0]    req_rs1,
  input  logic [32*N_REQ-1:0]    req_rs2,
  input  logic [TAG_W*N_REQ-1:0] req_tag,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_data,
  output logic [TAG_W-1:0]       resp_tag,
  output logic [ID_W-1:0]        resp_id
);

  mul_ctrl_state_t  state;
  logic             kill;
  logic [ID_W-1:0]  rr_ptr;

  mul_op_t          cap_op;
  rv32i_word        cap_rs1;
  rv32i_word        cap_rs2;
  logic [TAG_W-1:0] cap_tag;
  logic [ID_W-1:0]  cap_id;

  logic             grant_vld;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  rr_nxt;
  logic             accept;
  mul_op_t          g_op;
  rv32i_word        g_rs1;
  rv32i_word        g_rs2;
  logic [TAG_W-1:0] g_tag;

  logic             mult;
  logic             mult_resp;
  rv32i_word        product_l;
  rv32i_word        product_u;
  logic [1:0]       cap_signs;
  rv32i_word        sel_res;

  logic             hit;
  rv32i_word        hit_data;

  // first valid port at or after rr_ptr
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = ID_W'(idx);
      end
    end
  end

  assign accept    = (state == IDLE) && grant_vld && !flush;
  assign req_ready = accept ? (N_REQ'(1) << grant) : '0;
  assign rr_nxt    = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);

  assign g_op  = mul_op_t'(req_op[int'(grant)*2 +: 2]);
  assign g_rs1 = req_rs1[int'(grant)*32 +: 32];
  assign g_rs2 = req_rs2[int'(grant)*32 +: 32];
  assign g_tag = req_tag[int'(grant)*TAG_W +: TAG_W];

  assign mult      = (state == BUSY);
  assign cap_signs = mul_signs(cap_op);
  assign sel_res   = (cap_op == MUL) ? product_l : product_u;

  booth u_booth (
    .clk         (clk),
    .rst         (~rst_n),
    .mult        (mult),
    .licand      (cap_rs1),
    .lier        (cap_rs2),
    .licand_sign (cap_signs[1]),
    .lier_sign   (cap_signs[0]),
    .mult_resp   (mult_resp),
    .product_l   (product_l),
    .product_u   (product_u)
  );

`ifdef MUL_FUSE_EN
  rv32i_word h_rs1;
  rv32i_word h_rs2;
  logic      h_ls;
  logic      h_rs;
  rv32i_word h_pl;
  rv32i_word h_pu;
  logic      hit_v;

  // killed results still refresh the held set: the product itself is valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_rs1 <= '0;
      h_rs2 <= '0;
      h_ls  <= 1'b0;
      h_rs  <= 1'b0;
      h_pl  <= '0;
      h_pu  <= '0;
      hit_v <= 1'b0;
    end else if ((state == BUSY) && mult_resp) begin
      h_rs1 <= cap_rs1;
      h_rs2 <= cap_rs2;
      h_ls  <= cap_signs[1];
      h_rs  <= cap_signs[0];
      h_pl  <= product_l;
      h_pu  <= product_u;
      hit_v <= 1'b1;
    end
  end

  assign hit      = hit_v && (g_rs1 == h_rs1) && (g_rs2 == h_rs2) &&
                    ((g_op == MUL) || ({h_ls, h_rs} == mul_signs(g_op)));
  assign hit_data = (g_op == MUL) ? h_pl : h_pu;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      kill      <= 1'b0;
      rr_ptr    <= '0;
      cap_op    <= MUL;
      cap_rs1   <= '0;
      cap_rs2   <= '0;
      cap_tag   <= '0;
      cap_id    <= '0;
      resp_data <= '0;
      resp_tag  <= '0;
      resp_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_op  <= g_op;
            cap_rs1 <= g_rs1;
            cap_rs2 <= g_rs2;
            cap_tag <= g_tag;
            cap_id  <= grant;
            rr_ptr  <= rr_nxt;
            if (hit) begin
              resp_data <= hit_data;
              resp_tag  <= g_tag;
              resp_id   <= grant;
              state     <= RESP;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          // booth cannot abort, so a flush only marks the op for discard
          if (mult_resp) begin
            kill <= 1'b0;
            if (kill || flush) begin
              state <= IDLE;
            end else begin
              resp_data <= sel_res;
              resp_tag  <= cap_tag;
              resp_id   <= cap_id;
              state     <= RESP;
            end
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        RESP: begin
          if (flush || resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state == RESP) && !flush;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl: scoreboarded results, latency, arbitration, flush and reset cases.
module tb_mul_ctrl;
  import rv32i_types::*;

  localparam int N_REQ = 2;
  localparam int TAG_W = 6;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [2*N_REQ-1:0]     req_op;
  logic [32*N_REQ-1:0]    req_rs1;
  logic [32*N_REQ-1:0]    req_rs2;
  logic [TAG_W*N_REQ-1:0] req_tag;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [31:0]            resp_data;
  logic [TAG_W-1:0]       resp_tag;
  logic [0:0]             resp_id;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             id;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   hs_cnt = 0;
  int   passed = 0;
  int   total  = 0;
  int   rr     = 0;

  mul_ctrl #(.N_REQ(N_REQ), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (resp_valid && resp_ready) hs_cnt <= hs_cnt + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=cycle %0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // independent reference: 64-bit product of the sign/zero extended operands
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (op != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
    y = (op == 2'b00 || op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic drive(input int p, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] t);
    req_op[p*2 +: 2]         = op;
    req_rs1[p*32 +: 32]      = a;
    req_rs2[p*32 +: 32]      = b;
    req_tag[p*TAG_W +: TAG_W] = t;
    req_valid[p]             = 1'b1;
  endtask

  task automatic push(input int p, input logic [31:0] d, input logic [TAG_W-1:0] t);
    exp_t e;
    e.data = d;
    e.tag  = t;
    e.id   = 1'(p);
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept(input int p, output int acc);
    bit got;
    got = 1'b0;
    acc = cyc;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    check("accept_seen", 64'(got), 64'd1);
    if (got) begin
      check("ready_onehot", 64'(req_ready), 64'd1 << p);
      @(posedge clk);
      #1;
    end
    req_valid[p] = 1'b0;
  endtask

  task automatic get_resp(input int acc, input int lat);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    check("resp_seen", 64'(got), 64'd1);
    if (got) begin
      if (lat >= 0) check("latency", 64'(cyc - acc), 64'(lat));
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("resp_data", 64'(resp_data), 64'(e.data));
        check("resp_tag", 64'(resp_tag), 64'(e.tag));
        check("resp_id", 64'(resp_id), 64'(e.id));
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input int p, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [TAG_W-1:0] t, input logic [31:0] exp, input int lat);
    int acc;
    drive(p, op, a, b, t);
    push(p, exp, t);
    accept(p, acc);
    get_resp(acc, lat);
    rr = (p + 1) % N_REQ;
  endtask

  initial begin
    int acc, acc2, hs0, e;
    bit got;
    rst_n      = 1'b0;
    flush      = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_tag    = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_tag", 64'(resp_tag), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(0, MUL, 32'd7, 32'd6, 6'd5, 32'h0000002A, 36);
    run(1, MULH, 32'hFFFFFFFE, 32'd3, 6'd7, 32'hFFFFFFFF, 36);
    run(0, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd8, 32'hFFFFFFFE, 36);
    run(1, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd9, 32'hFFFFFFFF, 36);
    run(0, MULHSU, 32'd2, 32'h80000000, 6'd10, 32'h00000001, 36);

    // both ports valid: alternating grants, one response stalled for 10 cycles
    drive(0, MUL, 32'd1000, 32'd3, 6'd12);
    drive(1, MULHU, 32'h12345678, 32'h9ABCDEF0, 6'd13);
    for (int k = 0; k < 4; k++) begin
      e   = rr;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        if (req_ready != '0) got = 1'b1;
      end
      check("rr_seen", 64'(got), 64'd1);
      check("rr_grant", 64'(req_ready), 64'd1 << e);
      if (e == 0) push(0, model(MUL, 32'd1000, 32'd3), 6'd12);
      else        push(1, model(MULHU, 32'h12345678, 32'h9ABCDEF0), 6'd13);
      acc = cyc;
      @(posedge clk);
      #1;
      if (k == 1) begin
        resp_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
          @(negedge clk);
          if (resp_valid) got = 1'b1;
        end
        check("stall_latency", 64'(cyc - acc), 64'd36);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("stall_valid", 64'(resp_valid), 64'd1);
          if (sb.size() != 0) check("stall_data", 64'(resp_data), 64'(sb[0].data));
          check("stall_no_accept", 64'(req_ready), 64'd0);
        end
        get_resp(acc, -1);
      end else begin
        get_resp(acc, 36);
      end
      rr = (e + 1) % N_REQ;
    end
    req_valid = '0;

    // flush in BUSY cycle 10: op dropped, next accept only after mult_resp
    hs0 = hs_cnt;
    drive(0, MULH, 32'h11111111, 32'h22222222, 6'd20);
    accept(0, acc);
    wait_cyc(acc + 11);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    drive(1, MUL, 32'd123, 32'd456, 6'd21);
    push(1, model(MUL, 32'd123, 32'd456), 6'd21);
    accept(1, acc2);
    check("flush_ready_gap", 64'(acc2 - acc), 64'd36);
    get_resp(acc2, 36);
    check("flush_drop_count", 64'(hs_cnt - hs0), 64'd1);

    // flush coincident with mult_resp
    hs0 = hs_cnt;
    drive(0, MULHU, 32'hDEADBEEF, 32'h0BADF00D, 6'd22);
    accept(0, acc);
    wait_cyc(acc + 35);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    drive(1, MULHSU, 32'h80000000, 32'd5, 6'd23);
    push(1, model(MULHSU, 32'h80000000, 32'd5), 6'd23);
    accept(1, acc2);
    check("flush_resp_gap", 64'(acc2 - acc), 64'd36);
    get_resp(acc2, 36);
    check("flush_resp_drop_count", 64'(hs_cnt - hs0), 64'd1);

    // reset in the middle of BUSY
    drive(1, MUL, 32'h0F0F0F0F, 32'h00FF00FF, 6'd30);
    accept(1, acc);
    wait_cyc(acc + 15);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_resp_data", 64'(resp_data), 64'd0);
    check("midrst_resp_tag", 64'(resp_tag), 64'd0);
    check("midrst_resp_id", 64'(resp_id), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(1, MULH, 32'h7FFFFFFF, 32'h7FFFFFFF, 6'd31, 32'h3FFFFFFF, 36);

`ifdef MUL_FUSE_EN
    run(0, MUL, 32'd7, 32'd6, 6'd5, 32'h0000002A, 36);
    run(0, MUL, 32'd7, 32'd6, 6'd14, 32'h0000002A, 1);
`else
    run(0, MUL, 32'd7, 32'd6, 6'd5, 32'h0000002A, 36);
    run(0, MUL, 32'd7, 32'd6, 6'd14, 32'h0000002A, 36);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
